cajero_automatico_ctrl: RTL and testbench

CAJERO_AUTOMATICO_CTRL -- requirements
Module: cajero_automatico_ctrl

---
 rtl/cajero_automatico_ctrl.sv | 176 +++++++++++++++++
 tb/tb_cajero_automatico_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cajero_automatico_ctrl.sv
// ATM controller: interlocked access, menu and withdrawal Moore FSMs.
// Define CAJERO_RECIBO_EN to include the RECEIPT state after a balance query.
module cajero_automatico_ctrl #(
  parameter logic [3:0] CARD_ID  = 4'b0001,
  parameter logic [3:0] PIN_CODE = 4'b0001
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       atras,
  input  logic       consulta,
  input  logic       retiro,
  input  logic       next,
  input  logic       si,
  input  logic       no,
  input  logic       otro_mon,
  input  logic [4:0] cant,
  input  logic       valido,
  input  logic       invalido,
  output logic       solicitar_tarjeta,
  output logic       solicitar_pin,
  output logic       acceso,
  output logic       sel_menu,
  output logic       consult,
  output logic       recibo,
  output logic       otra_ope,
  output logic       tarjeta,
  output logic       retiro_m,
  output logic       valida,
  output logic       invalida,
  output logic       efectivo,
  output logic [4:0] opcion,
  output logic [1:0] st1,
  output logic [2:0] st2,
  output logic [3:0] st3
);

  typedef enum logic [1:0] {
    ACC_IDLE   = 2'd0,
    ACC_PIN    = 2'd1,
    ACC_ACCESS = 2'd2
  } acc_state_t;

  typedef enum logic [2:0] {
    M_MENU     = 3'd0,
    M_CONSULT  = 3'd1,
    M_RECEIPT  = 3'd2,
    M_WITHDRAW = 3'd3,
    M_OTHER    = 3'd4,
    M_CARD     = 3'd5
  } menu_state_t;

  typedef enum logic [3:0] {
    W_IDLE     = 4'd0,
    W_OPT1     = 4'd1,
    W_OPT2     = 4'd2,
    W_OPT3     = 4'd3,
    W_OPT4     = 4'd4,
    W_OPT5     = 4'd5,
    W_DISPENSE = 4'd6,
    W_INVALID  = 4'd7,
    W_ASK      = 4'd8,
    W_ASK_YES  = 4'd9,
    W_ASK_NO   = 4'd10
  } wd_state_t;

  acc_state_t  r_st1;
  menu_state_t r_st2;
  wd_state_t   r_st3;
  logic [4:0]  w_opcion;

  // Each FSM reads the others' current state, so the interlocks act one clock later.
  // NOTE: non-blocking assignments make every branch see pre-edge state regardless of order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st1 <= ACC_IDLE;
      r_st2 <= M_MENU;
      r_st3 <= W_IDLE;
    end else begin
      case (r_st1)
        ACC_IDLE:   if (a == CARD_ID) r_st1 <= ACC_PIN;
        ACC_PIN:    if (atras) r_st1 <= ACC_IDLE;
                    else if (b == PIN_CODE) r_st1 <= ACC_ACCESS;
        ACC_ACCESS: if (r_st2 == M_CARD) r_st1 <= ACC_IDLE;
        default:    r_st1 <= ACC_IDLE;
      endcase

      if (r_st1 != ACC_ACCESS) begin
        r_st2 <= M_MENU;
      end else begin
        case (r_st2)
          M_MENU:     if (consulta) r_st2 <= M_CONSULT;
                      else if (retiro) r_st2 <= M_WITHDRAW;
          M_CONSULT:  if (next) begin
`ifdef CAJERO_RECIBO_EN
                        r_st2 <= M_RECEIPT;
`else
                        r_st2 <= M_OTHER;
`endif
                      end
`ifdef CAJERO_RECIBO_EN
          M_RECEIPT:  if (si || no) r_st2 <= M_OTHER;
`endif
          M_WITHDRAW: if (r_st3 == W_ASK_YES) r_st2 <= M_MENU;
                      else if (r_st3 == W_ASK_NO) r_st2 <= M_CARD;
          M_OTHER:    if (si) r_st2 <= M_MENU;
                      else if (no) r_st2 <= M_CARD;
          M_CARD:     r_st2 <= M_MENU;
          default:    r_st2 <= M_MENU;
        endcase
      end

      if (r_st2 != M_WITHDRAW) begin
        r_st3 <= W_IDLE;
      end else begin
        case (r_st3)
          W_IDLE: begin
            if      (cant[0]) r_st3 <= W_OPT1;
            else if (cant[1]) r_st3 <= W_OPT2;
            else if (cant[2]) r_st3 <= W_OPT3;
            else if (cant[3]) r_st3 <= W_OPT4;
            else if (cant[4]) r_st3 <= W_OPT5;
          end
          W_OPT1, W_OPT2, W_OPT3, W_OPT4, W_OPT5:
                      if (invalido) r_st3 <= W_INVALID;
                      else if (valido) r_st3 <= W_DISPENSE;
          W_DISPENSE: if (next) r_st3 <= W_ASK;
          W_INVALID:  if (otro_mon) r_st3 <= W_IDLE;
                      else if (next) r_st3 <= W_ASK;
          W_ASK:      if (si) r_st3 <= W_ASK_YES;
                      else if (no) r_st3 <= W_ASK_NO;
          W_ASK_YES, W_ASK_NO: r_st3 <= W_IDLE;
          default:    r_st3 <= W_IDLE;
        endcase
      end
    end
  end

  // NOTE: default assignment first so no path leaves w_opcion unassigned (no latch).
  always_comb begin
    w_opcion = 5'b00000;
    case (r_st3)
      W_OPT1:  w_opcion = 5'b00001;
      W_OPT2:  w_opcion = 5'b00010;
      W_OPT3:  w_opcion = 5'b00100;
      W_OPT4:  w_opcion = 5'b01000;
      W_OPT5:  w_opcion = 5'b10000;
      default: w_opcion = 5'b00000;
    endcase
  end

  // Outputs are pure decodes of the state registers, so they follow reset asynchronously.
  assign solicitar_tarjeta = (r_st1 == ACC_IDLE);
  assign solicitar_pin     = (r_st1 == ACC_PIN);
  assign acceso            = (r_st1 == ACC_ACCESS);
  // The menu idles in MENU outside a session; only flag selection when it is live.
  assign sel_menu          = (r_st1 == ACC_ACCESS) && (r_st2 == M_MENU);
  assign consult           = (r_st2 == M_CONSULT);
`ifdef CAJERO_RECIBO_EN
  assign recibo            = (r_st2 == M_RECEIPT);
`else
  assign recibo            = 1'b0;
`endif
  assign otra_ope          = (r_st2 == M_OTHER) || (r_st3 == W_ASK);
  assign tarjeta           = (r_st2 == M_CARD);
  assign retiro_m          = (r_st2 == M_WITHDRAW);
  assign valida            = (r_st3 == W_DISPENSE);
  assign invalida          = (r_st3 == W_INVALID);
  assign efectivo          = (r_st3 == W_DISPENSE);
  assign opcion            = w_opcion;
  assign st1               = r_st1;
  assign st2               = r_st2;
  assign st3               = r_st3;

endmodule

// File: tb/tb_cajero_automatico_ctrl.sv
// Testbench for cajero_automatico_ctrl: directed scenarios plus randomized run
// against a behavioural model of the ATM session rules.
module tb_cajero_automatico_ctrl;

  localparam logic [3:0] CARD_ID  = 4'b0001;
  localparam logic [3:0] PIN_CODE = 4'b0001;
`ifdef CAJERO_RECIBO_EN
  localparam bit RECIBO = 1'b1;
`else
  localparam bit RECIBO = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] a, b;
  logic       atras, consulta, retiro, next, si, no, otro_mon, valido, invalido;
  logic [4:0] cant;
  logic       solicitar_tarjeta, solicitar_pin, acceso, sel_menu, consult, recibo;
  logic       otra_ope, tarjeta, retiro_m, valida, invalida, efectivo;
  logic [4:0] opcion;
  logic [1:0] st1;
  logic [2:0] st2;
  logic [3:0] st3;

  int checks = 0;
  int errors = 0;
  int m_acc, m_menu, m_wd;

  cajero_automatico_ctrl #(.CARD_ID(CARD_ID), .PIN_CODE(PIN_CODE)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .atras(atras),
    .consulta(consulta), .retiro(retiro), .next(next), .si(si), .no(no),
    .otro_mon(otro_mon), .cant(cant), .valido(valido), .invalido(invalido),
    .solicitar_tarjeta(solicitar_tarjeta), .solicitar_pin(solicitar_pin),
    .acceso(acceso), .sel_menu(sel_menu), .consult(consult), .recibo(recibo),
    .otra_ope(otra_ope), .tarjeta(tarjeta), .retiro_m(retiro_m),
    .valida(valida), .invalida(invalida), .efectivo(efectivo),
    .opcion(opcion), .st1(st1), .st2(st2), .st3(st3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [25:0] obs = {solicitar_tarjeta, solicitar_pin, acceso, sel_menu, consult, recibo,
                     otra_ope, tarjeta, retiro_m, valida, invalida, efectivo,
                     opcion, st1, st2, st3};

  // Expected outputs for a given (access, menu, withdrawal) state code triple.
  function automatic logic [25:0] expect_vec(input int ma, input int mm, input int mw);
    logic [4:0] opc;
    opc = (mw >= 1 && mw <= 5) ? 5'(1 << (mw - 1)) : 5'd0;
    return {ma == 0, ma == 1, ma == 2, (ma == 2 && mm == 0), mm == 1,
            (RECIBO && mm == 2), (mm == 4 || mw == 8), mm == 5, mm == 3,
            mw == 6, mw == 7, mw == 6, opc, 2'(ma), 3'(mm), 4'(mw)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    a = 4'd0; b = 4'd0; atras = 1'b0; consulta = 1'b0; retiro = 1'b0; next = 1'b0;
    si = 1'b0; no = 1'b0; otro_mon = 1'b0; cant = 5'd0; valido = 1'b0; invalido = 1'b0;
  endtask

  task automatic reset_dut();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic login();
    reset_dut();
    a = CARD_ID; tick(); a = 4'd0;
    b = PIN_CODE; tick(); b = 4'd0;
  endtask

  task automatic model_step();
    int na, nm, nw;
    na = m_acc; nm = m_menu; nw = m_wd;
    if (m_acc == 0) begin
      if (a == CARD_ID) na = 1;
    end else if (m_acc == 1) begin
      if (atras) na = 0;
      else if (b == PIN_CODE) na = 2;
    end else if (m_menu == 5) na = 0;

    if (m_acc != 2) nm = 0;
    else case (m_menu)
      0: if (consulta) nm = 1; else if (retiro) nm = 3;
      1: if (next) nm = RECIBO ? 2 : 4;
      2: if (si || no) nm = 4;
      3: if (m_wd == 9) nm = 0; else if (m_wd == 10) nm = 5;
      4: if (si) nm = 0; else if (no) nm = 5;
      default: nm = 0;
    endcase

    if (m_menu != 3) nw = 0;
    else if (m_wd == 0) begin
      for (int k = 5; k >= 1; k--) if (cant[k-1]) nw = k;
    end else if (m_wd <= 5) begin
      if (invalido) nw = 7; else if (valido) nw = 6;
    end else if (m_wd == 6) begin
      if (next) nw = 8;
    end else if (m_wd == 7) begin
      if (otro_mon) nw = 0; else if (next) nw = 8;
    end else if (m_wd == 8) begin
      if (si) nw = 9; else if (no) nw = 10;
    end else nw = 0;

    m_acc = na; m_menu = nm; m_wd = nw;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #3;
    checks++; if (obs !== expect_vec(0, 0, 0)) begin errors++; $display("FAIL reset_async: got %h expected %h", obs, expect_vec(0, 0, 0)); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (obs !== expect_vec(0, 0, 0)) begin errors++; $display("FAIL reset_idle_hold: got %h expected %h", obs, expect_vec(0, 0, 0)); end
  endtask

  task automatic test_login();
    reset_dut();
    a = CARD_ID; tick(); a = 4'd0;
    checks++; if (obs !== expect_vec(1, 0, 0)) begin errors++; $display("FAIL login_pin: got %h expected %h", obs, expect_vec(1, 0, 0)); end
    b = PIN_CODE; tick(); b = 4'd0;
    checks++; if (obs !== expect_vec(2, 0, 0) || acceso !== 1'b1) begin errors++; $display("FAIL login_access: got %h expected %h", obs, expect_vec(2, 0, 0)); end
  endtask

  task automatic test_pin_back();
    reset_dut();
    a = CARD_ID; tick(); a = 4'd0;
    b = 4'd2; tick(); b = 4'd0;
    checks++; if (obs !== expect_vec(1, 0, 0)) begin errors++; $display("FAIL pin_wrong_hold: got %h expected %h", obs, expect_vec(1, 0, 0)); end
    atras = 1'b1; b = PIN_CODE; tick(); atras = 1'b0; b = 4'd0;
    checks++; if (obs !== expect_vec(0, 0, 0) || solicitar_tarjeta !== 1'b1) begin errors++; $display("FAIL pin_back_priority: got %h expected %h", obs, expect_vec(0, 0, 0)); end
  endtask

  task automatic test_consult();
    login();
    consulta = 1'b1; tick(); consulta = 1'b0;
    checks++; if (obs !== expect_vec(2, 1, 0)) begin errors++; $display("FAIL consult_enter: got %h expected %h", obs, expect_vec(2, 1, 0)); end
    next = 1'b1; tick(); next = 1'b0;
    if (RECIBO) begin
      checks++; if (obs !== expect_vec(2, 2, 0)) begin errors++; $display("FAIL consult_receipt: got %h expected %h", obs, expect_vec(2, 2, 0)); end
      si = 1'b1; tick(); si = 1'b0;
    end
    checks++; if (obs !== expect_vec(2, 4, 0)) begin errors++; $display("FAIL consult_other: got %h expected %h", obs, expect_vec(2, 4, 0)); end
    no = 1'b1; tick(); no = 1'b0;
    checks++; if (obs !== expect_vec(2, 5, 0) || tarjeta !== 1'b1) begin errors++; $display("FAIL consult_card: got %h expected %h", obs, expect_vec(2, 5, 0)); end
    tick();
    checks++; if (obs !== expect_vec(0, 0, 0)) begin errors++; $display("FAIL consult_logout: got %h expected %h", obs, expect_vec(0, 0, 0)); end
  endtask

  task automatic test_withdraw();
    login();
    retiro = 1'b1; tick(); retiro = 1'b0;
    checks++; if (obs !== expect_vec(2, 3, 0)) begin errors++; $display("FAIL wd_enter: got %h expected %h", obs, expect_vec(2, 3, 0)); end
    cant = 5'b00100; tick(); cant = 5'd0;
    checks++; if (obs !== expect_vec(2, 3, 3) || opcion !== 5'b00100) begin errors++; $display("FAIL wd_opt3: got %h expected %h", obs, expect_vec(2, 3, 3)); end
    valido = 1'b1; tick(); valido = 1'b0;
    checks++; if (obs !== expect_vec(2, 3, 6) || efectivo !== 1'b1) begin errors++; $display("FAIL wd_dispense: got %h expected %h", obs, expect_vec(2, 3, 6)); end
    next = 1'b1; tick(); next = 1'b0;
    checks++; if (obs !== expect_vec(2, 3, 8)) begin errors++; $display("FAIL wd_ask: got %h expected %h", obs, expect_vec(2, 3, 8)); end
    si = 1'b1; tick(); si = 1'b0;
    checks++; if (obs !== expect_vec(2, 3, 9)) begin errors++; $display("FAIL wd_ask_yes: got %h expected %h", obs, expect_vec(2, 3, 9)); end
    tick();
    checks++; if (obs !== expect_vec(2, 0, 0)) begin errors++; $display("FAIL wd_back_menu: got %h expected %h", obs, expect_vec(2, 0, 0)); end
  endtask

  task automatic test_invalid();
    login();
    retiro = 1'b1; tick(); retiro = 1'b0;
    cant = 5'b11001; tick(); cant = 5'd0;
    checks++; if (obs !== expect_vec(2, 3, 1)) begin errors++; $display("FAIL inv_opt1_lowest: got %h expected %h", obs, expect_vec(2, 3, 1)); end
    valido = 1'b1; invalido = 1'b1; tick(); valido = 1'b0; invalido = 1'b0;
    checks++; if (obs !== expect_vec(2, 3, 7) || efectivo !== 1'b0) begin errors++; $display("FAIL inv_priority: got %h expected %h", obs, expect_vec(2, 3, 7)); end
    otro_mon = 1'b1; next = 1'b1; tick(); otro_mon = 1'b0; next = 1'b0;
    checks++; if (obs !== expect_vec(2, 3, 0) || efectivo !== 1'b0) begin errors++; $display("FAIL inv_otro_mon: got %h expected %h", obs, expect_vec(2, 3, 0)); end
  endtask

  task automatic test_async_reset();
    login();
    retiro = 1'b1; tick(); retiro = 1'b0;
    cant = 5'b00010; tick(); cant = 5'd0;
    valido = 1'b1; tick(); valido = 1'b0;
    checks++; if (obs !== expect_vec(2, 3, 6)) begin errors++; $display("FAIL ares_dispense: got %h expected %h", obs, expect_vec(2, 3, 6)); end
    rst_n = 1'b0;
    #1;
    checks++; if (obs !== expect_vec(0, 0, 0) || efectivo !== 1'b0) begin errors++; $display("FAIL ares_immediate: got %h expected %h", obs, expect_vec(0, 0, 0)); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (obs !== expect_vec(0, 0, 0)) begin errors++; $display("FAIL ares_after: got %h expected %h", obs, expect_vec(0, 0, 0)); end
  endtask

  task automatic test_random();
    logic [25:0] exp_v;
    reset_dut();
    m_acc = 0; m_menu = 0; m_wd = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      a        = ($urandom_range(0, 1) == 0) ? CARD_ID : 4'($urandom);
      b        = ($urandom_range(0, 2) == 0) ? PIN_CODE : 4'($urandom);
      atras    = ($urandom_range(0, 15) == 0);
      consulta = ($urandom_range(0, 3) == 0);
      retiro   = ($urandom_range(0, 2) == 0);
      next     = ($urandom_range(0, 3) == 0);
      si       = ($urandom_range(0, 3) == 0);
      no       = ($urandom_range(0, 3) == 0);
      otro_mon = ($urandom_range(0, 5) == 0);
      cant     = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom);
      valido   = ($urandom_range(0, 2) == 0);
      invalido = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        #1;
        m_acc = 0; m_menu = 0; m_wd = 0;
        exp_v = expect_vec(0, 0, 0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL rand_reset cyc %0d: got %h expected %h", cyc, obs, exp_v); end
        tick();
        rst_n = 1'b1;
      end else begin
        model_step();
        tick();
        exp_v = expect_vec(m_acc, m_menu, m_wd);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL rand cyc %0d: got %h expected %h", cyc, obs, exp_v); end
      end
    end
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    test_reset();
    test_login();
    test_pin_back();
    test_consult();
    test_withdraw();
    test_invalid();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
